// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit geometry and per-digit limits for the stopwatch.
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUNNING, STOPPED, LAP} state_e;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] C1_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] C10_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] S1_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] S10_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] M1_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] M10_MAX = 4'd9;
    localparam int C1_IDX  = 0;
    localparam int C10_IDX = 1;
    localparam int S1_IDX  = 2;
    localparam int S10_IDX = 3;
    localparam int M1_IDX  = 4;
    localparam int M10_IDX = 5;

    function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
        return idx == C1_IDX  ? C1_MAX  :
               idx == C10_IDX ? C10_MAX :
               idx == S1_IDX  ? S1_MAX  :
               idx == S10_IDX ? S10_MAX :
               idx == M1_IDX  ? M1_MAX  : M10_MAX;
    endfunction
endpackage

// File: rtl/stopwatch_controller_if.sv
// stopwatch_controller_if: button/tick inputs and display outputs of the stopwatch controller.
interface stopwatch_controller_if;
    logic        tick;
    logic        start_Stop;
    logic        lap;
    logic        clear;
    logic [23:0] time_Digits;
    logic        running;
    logic        lap_Active;
    logic        overflow;

    modport master (output tick, start_Stop, lap, clear,
                    input  time_Digits, running, lap_Active, overflow);
    modport slave  (input  tick, start_Stop, lap, clear,
                    output time_Digits, running, lap_Active, overflow);
endinterface

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit that rolls over at max_Value and carries to the next digit.
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               inc,
    input  logic [DIGIT_W-1:0] max_Value,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);
    logic [DIGIT_W-1:0] value_q, value_d;
    logic               at_max;

    always_comb begin
        at_max  = value_q == max_Value;
        carry   = inc && at_max;
        value_d = clear ? '0 : inc ? (at_max ? '0 : value_q + 4'd1) : value_q;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) value_q <= '0;
        else          value_q <= value_d;

    assign value = value_q;
endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: MM:SS.cc BCD stopwatch with start/stop, lap freeze, clear and sticky overflow.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int WRAP_MINUTES = 60
) (
    input logic             clock,
    input logic             reset_n,
    stopwatch_controller_if.slave bus
);
    state_e      state_q, state_d;
    logic [23:0] lap_q, lap_d, live;
    logic        overflow_q, overflow_d;
    logic [5:0]  inc, carry, clr;
    logic [6:0]  minutes;
    logic        count_en, wrap;

    assign count_en = bus.tick && (state_q == RUNNING || state_q == LAP);
    assign inc      = {carry[4:0], count_en};
    assign minutes  = {3'b0, live[M10_IDX*DIGIT_W +: DIGIT_W]} * 7'd10
                    + {3'b0, live[M1_IDX*DIGIT_W +: DIGIT_W]};
    // Seconds rolling over at the last legal minute forces both minute digits back to zero.
    assign wrap     = carry[M10_IDX] || (carry[S10_IDX] && minutes == 7'(WRAP_MINUTES - 1));
    assign clr      = {{2{bus.clear || wrap}}, {4{bus.clear}}};

    for (genvar i = 0; i < 6; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clock     (clock),
            .reset_n   (reset_n),
            .clear     (clr[i]),
            .inc       (inc[i]),
            .max_Value (digit_max(i)),
            .value     (live[i*DIGIT_W +: DIGIT_W]),
            .carry     (carry[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        lap_d      = lap_q;
        overflow_d = bus.clear ? 1'b0 : (overflow_q || wrap);
        if (bus.clear) begin
            state_d = IDLE;
            lap_d   = '0;
        end else begin
            unique case (state_q)
                IDLE:    state_d = bus.start_Stop ? RUNNING : IDLE;
                STOPPED: state_d = bus.start_Stop ? RUNNING : STOPPED;
                LAP:     state_d = bus.start_Stop ? STOPPED : bus.lap ? RUNNING : LAP;
                RUNNING: begin
                    state_d = bus.start_Stop ? STOPPED : bus.lap ? LAP : RUNNING;
                    lap_d   = (!bus.start_Stop && bus.lap) ? live : lap_q;
                end
                default: state_d = IDLE;
            endcase
        end
        bus.time_Digits = state_q == LAP ? lap_q : live;
        bus.running     = state_q == RUNNING || state_q == LAP;
        bus.lap_Active  = state_q == LAP;
        bus.overflow    = overflow_q;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state_q    <= IDLE;
            lap_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lap_q      <= lap_d;
            overflow_q <= overflow_d;
        end
endmodule

// File: tb/tb_stopwatch_controller.sv
// tb_stopwatch_controller: directed scenarios on a 60-minute stopwatch plus a 2-minute one for wrap.
module tb_stopwatch_controller;
    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;

    stopwatch_controller_if bus_m ();
    stopwatch_controller_if bus_w ();

    stopwatch_controller #(.WRAP_MINUTES(60)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_m)
    );

    stopwatch_controller #(.WRAP_MINUTES(2)) dut_w (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input logic t, input logic s, input logic l, input logic c);
        bus_m.tick = t; bus_m.start_Stop = s; bus_m.lap = l; bus_m.clear = c;
        @(posedge clock);
        #1;
        bus_m.tick = 0; bus_m.start_Stop = 0; bus_m.lap = 0; bus_m.clear = 0;
    endtask

    task automatic ticks(input int n);
        bus_m.tick = 1;
        repeat (n) @(posedge clock);
        #1;
        bus_m.tick = 0;
    endtask

    task automatic step_w(input logic s, input logic c);
        bus_w.start_Stop = s; bus_w.clear = c;
        @(posedge clock);
        #1;
        bus_w.start_Stop = 0; bus_w.clear = 0;
    endtask

    task automatic ticks_w(input int n);
        bus_w.tick = 1;
        repeat (n) @(posedge clock);
        #1;
        bus_w.tick = 0;
    endtask

    task automatic test_reset;
        vectors++; if (bus_m.time_Digits !== 24'h000000) begin miscompares++; $display("FAIL reset_time got %h exp %h", bus_m.time_Digits, 24'h000000); end
        vectors++; if (bus_m.running !== 1'b0) begin miscompares++; $display("FAIL reset_running got %b exp 0", bus_m.running); end
        vectors++; if (bus_m.lap_Active !== 1'b0) begin miscompares++; $display("FAIL reset_lap_active got %b exp 0", bus_m.lap_Active); end
        vectors++; if (bus_m.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b exp 0", bus_m.overflow); end
    endtask

    task automatic test_count;
        step(0, 1, 0, 0);
        vectors++; if (bus_m.running !== 1'b1) begin miscompares++; $display("FAIL start_running got %b exp 1", bus_m.running); end
        ticks(150);
        vectors++; if (bus_m.time_Digits !== 24'h000150) begin miscompares++; $display("FAIL count_150 got %h exp %h", bus_m.time_Digits, 24'h000150); end
        vectors++; if (bus_m.lap_Active !== 1'b0) begin miscompares++; $display("FAIL count_lap_active got %b exp 0", bus_m.lap_Active); end
    endtask

    task automatic test_wrap;
        step_w(1, 0);
        ticks_w(5999);
        vectors++; if (bus_w.time_Digits !== 24'h005999) begin miscompares++; $display("FAIL wrap_pre_minute got %h exp %h", bus_w.time_Digits, 24'h005999); end
        ticks_w(1);
        vectors++; if (bus_w.time_Digits !== 24'h010000) begin miscompares++; $display("FAIL minute_carry got %h exp %h", bus_w.time_Digits, 24'h010000); end
        vectors++; if (bus_w.overflow !== 1'b0) begin miscompares++; $display("FAIL minute_carry_overflow got %b exp 0", bus_w.overflow); end
        ticks_w(5999);
        vectors++; if (bus_w.time_Digits !== 24'h015999) begin miscompares++; $display("FAIL wrap_pre got %h exp %h", bus_w.time_Digits, 24'h015999); end
        ticks_w(1);
        vectors++; if (bus_w.time_Digits !== 24'h000000) begin miscompares++; $display("FAIL wrap_time got %h exp %h", bus_w.time_Digits, 24'h000000); end
        vectors++; if (bus_w.overflow !== 1'b1) begin miscompares++; $display("FAIL wrap_overflow got %b exp 1", bus_w.overflow); end
        ticks_w(1);
        vectors++; if (bus_w.time_Digits !== 24'h000001) begin miscompares++; $display("FAIL wrap_continue got %h exp %h", bus_w.time_Digits, 24'h000001); end
        vectors++; if (bus_w.overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_sticky got %b exp 1", bus_w.overflow); end
        step_w(0, 1);
        vectors++; if (bus_w.overflow !== 1'b0) begin miscompares++; $display("FAIL clear_overflow got %b exp 0", bus_w.overflow); end
        vectors++; if (bus_w.time_Digits !== 24'h000000) begin miscompares++; $display("FAIL clear_time_w got %h exp %h", bus_w.time_Digits, 24'h000000); end
    endtask

    task automatic test_lap;
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(42);
        vectors++; if (bus_m.time_Digits !== 24'h000042) begin miscompares++; $display("FAIL lap_pre got %h exp %h", bus_m.time_Digits, 24'h000042); end
        step(1, 0, 1, 0);
        vectors++; if (bus_m.time_Digits !== 24'h000042) begin miscompares++; $display("FAIL lap_frozen got %h exp %h", bus_m.time_Digits, 24'h000042); end
        vectors++; if (bus_m.lap_Active !== 1'b1) begin miscompares++; $display("FAIL lap_active got %b exp 1", bus_m.lap_Active); end
        vectors++; if (bus_m.running !== 1'b1) begin miscompares++; $display("FAIL lap_running got %b exp 1", bus_m.running); end
        ticks(10);
        vectors++; if (bus_m.time_Digits !== 24'h000042) begin miscompares++; $display("FAIL lap_still_frozen got %h exp %h", bus_m.time_Digits, 24'h000042); end
        step(0, 0, 1, 0);
        vectors++; if (bus_m.time_Digits !== 24'h000053) begin miscompares++; $display("FAIL lap_release got %h exp %h", bus_m.time_Digits, 24'h000053); end
        vectors++; if (bus_m.lap_Active !== 1'b0) begin miscompares++; $display("FAIL lap_release_active got %b exp 0", bus_m.lap_Active); end
        step(0, 0, 1, 0);
        ticks(3);
        step(0, 1, 0, 0);
        vectors++; if (bus_m.time_Digits !== 24'h000056) begin miscompares++; $display("FAIL lap_stop_live got %h exp %h", bus_m.time_Digits, 24'h000056); end
        vectors++; if (bus_m.running !== 1'b0) begin miscompares++; $display("FAIL lap_stop_running got %b exp 0", bus_m.running); end
    endtask

    task automatic test_stop_tick;
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(9);
        step(1, 1, 0, 0);
        vectors++; if (bus_m.time_Digits !== 24'h000010) begin miscompares++; $display("FAIL stop_tick got %h exp %h", bus_m.time_Digits, 24'h000010); end
        vectors++; if (bus_m.running !== 1'b0) begin miscompares++; $display("FAIL stop_running got %b exp 0", bus_m.running); end
        ticks(5);
        step(0, 0, 1, 0);
        vectors++; if (bus_m.time_Digits !== 24'h000010) begin miscompares++; $display("FAIL stopped_hold got %h exp %h", bus_m.time_Digits, 24'h000010); end
        vectors++; if (bus_m.lap_Active !== 1'b0) begin miscompares++; $display("FAIL stopped_lap_ignored got %b exp 0", bus_m.lap_Active); end
        step(1, 1, 0, 0);
        vectors++; if (bus_m.time_Digits !== 24'h000010) begin miscompares++; $display("FAIL resume_no_inc got %h exp %h", bus_m.time_Digits, 24'h000010); end
        vectors++; if (bus_m.running !== 1'b1) begin miscompares++; $display("FAIL resume_running got %b exp 1", bus_m.running); end
        step(0, 1, 0, 0);
    endtask

    task automatic test_priority;
        step(0, 1, 1, 1);
        vectors++; if (bus_m.time_Digits !== 24'h000000) begin miscompares++; $display("FAIL prio_time got %h exp %h", bus_m.time_Digits, 24'h000000); end
        vectors++; if (bus_m.running !== 1'b0) begin miscompares++; $display("FAIL prio_running got %b exp 0", bus_m.running); end
        vectors++; if (bus_m.overflow !== 1'b0) begin miscompares++; $display("FAIL prio_overflow got %b exp 0", bus_m.overflow); end
        step(1, 0, 1, 0);
        vectors++; if (bus_m.time_Digits !== 24'h000000) begin miscompares++; $display("FAIL idle_tick got %h exp %h", bus_m.time_Digits, 24'h000000); end
        vectors++; if (bus_m.lap_Active !== 1'b0) begin miscompares++; $display("FAIL idle_lap got %b exp 0", bus_m.lap_Active); end
    endtask

    task automatic test_async_reset;
        step(0, 1, 0, 0);
        ticks(19277);
        vectors++; if (bus_m.time_Digits !== 24'h031277) begin miscompares++; $display("FAIL pre_reset_time got %h exp %h", bus_m.time_Digits, 24'h031277); end
        #3 reset_n = 0;
        #1;
        vectors++; if (bus_m.time_Digits !== 24'h000000) begin miscompares++; $display("FAIL async_time got %h exp %h", bus_m.time_Digits, 24'h000000); end
        vectors++; if (bus_m.running !== 1'b0) begin miscompares++; $display("FAIL async_running got %b exp 0", bus_m.running); end
        vectors++; if (bus_m.lap_Active !== 1'b0) begin miscompares++; $display("FAIL async_lap_active got %b exp 0", bus_m.lap_Active); end
        vectors++; if (bus_m.overflow !== 1'b0) begin miscompares++; $display("FAIL async_overflow got %b exp 0", bus_m.overflow); end
        @(posedge clock);
        #1 reset_n = 1;
        ticks(5);
        vectors++; if (bus_m.time_Digits !== 24'h000000) begin miscompares++; $display("FAIL post_reset_idle got %h exp %h", bus_m.time_Digits, 24'h000000); end
        vectors++; if (bus_m.running !== 1'b0) begin miscompares++; $display("FAIL post_reset_running got %b exp 0", bus_m.running); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1;
        bus_m.tick = 0; bus_m.start_Stop = 0; bus_m.lap = 0; bus_m.clear = 0;
        bus_w.tick = 0; bus_w.start_Stop = 0; bus_w.lap = 0; bus_w.clear = 0;
        #2 reset_n = 0;
        #1;
        test_reset;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        test_count;
        test_wrap;
        test_lap;
        test_stop_tick;
        test_priority;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for the stopwatch datapath. It consumes the one-cycle 100 Hz tick from the clock divider: one pulse every 1,000,000 cycles of the 100 MHz `clock`, i.e. one centisecond. It accumulates elapsed time as six BCD digits (MM:SS.cc) and arbitrates the start/stop, lap and clear buttons through a four-state machine. The display driver reads its outputs directly.

## Interface
Parameters:
- `WRAP_MINUTES`, default 60: minute count at which time wraps to zero. Legal range 1..100.

Ports:
- `clock`  in  1  system clock, 100 MHz
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `tick`  in  1  one-cycle pulse from the divider, one per centisecond
- `start_Stop`  in  1  debounced one-cycle button pulse
- `lap`  in  1  debounced one-cycle button pulse
- `clear`  in  1  debounced one-cycle button pulse
- `time_Digits`  out  24  displayed time, BCD {m10,m1,s10,s1,c10,c1}
- `running`  out  1  high in RUNNING or LAP
- `lap_Active`  out  1  high in LAP (display frozen)
- `overflow`  out  1  sticky; set on wrap to 00:00.00

## Operation
- States: IDLE, RUNNING, STOPPED, LAP.
- Input priority when inputs coincide: `clear` > `start_Stop` > `lap`. A lower-priority pulse in the same cycle is discarded.
- `clear`, from any state: go to IDLE, zero the live time, zero the lap time, clear `overflow`.
- IDLE:
  - `start_Stop` -> RUNNING.
  - `lap` ignored.
  - `tick` ignored.
- RUNNING:
  - each `tick` increments the live time.
  - `start_Stop` -> STOPPED.
  - `lap` -> LAP, and the lap register captures the live time.
- LAP:
  - `tick` keeps incrementing the live time; `time_Digits` shows the lap register.
  - `lap` -> RUNNING, and the display returns to live time.
  - `start_Stop` -> STOPPED, and the display shows live time.
- STOPPED:
  - `start_Stop` -> RUNNING; live time is preserved.
  - `lap` ignored.
  - `tick` ignored.
- Counting is gated by the current state. The `tick` is applied when the state at the start of that cycle is RUNNING or LAP.
  - RUNNING with `tick` and `start_Stop` in the same cycle: the increment happens, then the state becomes STOPPED.
  - STOPPED with `tick` and `start_Stop` in the same cycle: no increment, then the state becomes RUNNING.
  - RUNNING with `tick` and `lap` in the same cycle: the lap register captures the pre-increment value; live time increments.
- Arithmetic: cascaded BCD digits.
  - Digit limits: c1 0-9, c10 0-9, s1 0-9, s10 0-5, m1 0-9, m10 0-9.
  - Each digit carries to the next at its limit.
  - Minutes wrap when the minute value (m10*10+m1) reaches `WRAP_MINUTES`.
- Wrap: incrementing from (WRAP_MINUTES-1):59.99 yields 00:00.00 and sets `overflow`. Counting continues.
- Reset (asynchronous, mid-operation included): state IDLE; live time, lap register, `time_Digits`, `running`, `lap_Active` and `overflow` all 0.

## Timing
- All state, time and lap registers update on posedge `clock`.
- `time_Digits`, `running` and `lap_Active` are combinational decodes of registers. They reflect an event on the first clock edge after it (latency 1 cycle).
- `overflow` is asserted on the same edge as the wrap.
- No handshake: input pulses are single-cycle; a pulse held high for N cycles is treated as N pulses.
- `tick` may arrive in any cycle; no minimum spacing is assumed.

## Structure
- Package `stopwatch_pkg` contains:
  - state enum (IDLE, RUNNING, STOPPED, LAP)
  - `DIGIT_W = 4`
  - per-digit limit constants
  - digit index constants for packing `time_Digits`
- Sub-module `bcd_digit_counter`: one digit, with ports `clock`, `reset_n`, `clear`, `inc`, `max_Value[3:0]`, `value[3:0]`, `carry`.
  - `carry` = `inc` && value == max.
  - Six instances in a chain; the minute-wrap compare lives in the top level.

## Test plan
- Reset, then `start_Stop`, then 150 ticks -> `time_Digits` = 00:01.50, `running` = 1.
- Preload 00:59.99 in RUNNING plus one tick -> 01:00.00. With WRAP_MINUTES=60, 59:59.99 plus one tick -> 00:00.00 and `overflow` = 1.
- RUNNING at 00:00.42, `lap` and `tick` in the same cycle -> display frozen at 00:00.42. After 10 more ticks, the next `lap` shows 00:00.53.
- RUNNING, `tick` and `start_Stop` together at 00:00.09 -> STOPPED showing 00:00.10. Further ticks leave it unchanged.
- STOPPED with `clear`, `start_Stop` and `lap` all asserted together -> IDLE, 00:00.00, `overflow` = 0, `running` = 0.
- Deassert `reset_n` asynchronously mid-RUNNING at 03:12.77 -> all outputs 0 before the next clock edge. On release, IDLE ignores ticks.
